// File: rtl/instr_encoder_loader.sv
// Encodes RV32I R/I/load/store/branch field bundles into 32-bit words and writes
// them sequentially into instruction memory, one word per accepted bundle.
module instr_encoder_loader #(
  parameter int          DEPTH     = 32,
  parameter int          CNT_W     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [12:0]      imm_i,
  input  logic             last_i,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             full_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_legal;
  logic [31:0]      w_word;
  logic [CNT_W-1:0] w_count_inc;
  logic [31:0]      w_addr;

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [12:0] imm
  );
    logic [31:0] word;
    case (op)
      3'b000:  word = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      3'b001: begin
        // Shift-immediates carry funct7 bit 30 and a 5-bit shamt instead of imm[11:5]
        if (f3 == 3'b001 || f3 == 3'b101)
          word = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
        else
          word = {imm[11:0], rs1, f3, rd, 7'b0010011};
      end
      3'b010:  word = {imm[11:0], rs1, f3, rd, 7'b0000011};
      3'b011:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'b100:  word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  assign w_accept    = req_valid_i & req_ready_o;
  assign w_legal     = (op_i <= 3'b100) && !((op_i == 3'b100) && imm_i[0]);
  assign w_word      = encode(op_i, funct3_i, funct7b5_i, rd_i, rs1_i, rs2_i, imm_i);
  assign w_count_inc = r_count + LP_ONE;
  assign w_addr      = BASE_ADDR + {{(30-CNT_W){1'b0}}, r_count, 2'b00};
  assign count_o     = r_count;
  assign full_o      = (r_count == LP_DEPTH);

  // Session FSM with all handshake and memory-port outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b0;
      r_count     <= {CNT_W{1'b0}};
      req_ready_o <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0000_0000;
      mem_wdata_o <= 32'h0000_0000;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          mem_we_o <= 1'b0;
          if (start_i) begin
            r_state     <= S_RECV;
            r_count     <= {CNT_W{1'b0}};
            err_o       <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        S_RECV: begin
          mem_we_o <= 1'b0;
          if (w_accept) begin
            if (w_legal) begin
              r_state     <= S_WRITE;
              r_last      <= last_i;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= w_addr;
              mem_wdata_o <= w_word;
              req_ready_o <= 1'b0;
            end else begin
              err_o <= 1'b1;
              if (last_i) begin
                r_state     <= S_DONE;
                req_ready_o <= 1'b0;
                busy_o      <= 1'b0;
              end
            end
          end
        end
        S_WRITE: begin
          mem_we_o <= 1'b0;
          r_count  <= w_count_inc;
          if (r_last || (w_count_inc == LP_DEPTH)) begin
            r_state     <= S_DONE;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b0;
          end else begin
            r_state     <= S_RECV;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          mem_we_o    <= 1'b0;
          req_ready_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
